midi_voice_alloc: RTL and testbench
===================================

Name: midi_voice_alloc

Overview:
- Polyphonic voice allocator between the MIDI byte receiver and the per-voice oscillator/frequency path.
- Takes completed 3-byte MIDI messages and assigns each note-on to one of NUM_VOICES voices: retrigger first, then a free voice, then steal the oldest.
- Releases voices on note-off.
- Presents registered per-voice note/velocity/gate lanes that feed one MIDI-to-frequency converter per voice.

Parameters:
- NUM_VOICES, 4, number of voices (2..16).
- CHANNEL_FILTER, 0, 1 = accept only messages on MIDI_CHANNEL; 0 = accept any channel.
- MIDI_CHANNEL, 0, 4-bit channel compared against status[3:0] when CHANNEL_FILTER=1.

Ports:
- clk  in  1  system clock; the only clock in the block.
- rst_n  in  1  synchronous, active-low reset.
- i_midi_bytes  in  24  [23:16] status, [15:8] note, [7:0] velocity.
- i_midi_valid  in  1  one-cycle strobe; i_midi_bytes is valid in that cycle.
- o_busy  out  1  allocator processing a message.
- o_drop  out  1  one-cycle pulse: a message was discarded because it arrived while busy.
- o_steal  out  1  one-cycle pulse: a sounding voice was stolen.
- o_voice_gate  out  NUM_VOICES  per-voice gate.
- o_voice_trig  out  NUM_VOICES  one-cycle pulse when a voice is (re)assigned.
- o_voice_note  out  7*NUM_VOICES  voice i occupies [7i+6:7i].
- o_voice_vel  out  7*NUM_VOICES  voice i occupies [7i+6:7i].

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All gates, notes, vels, trig, steal, drop and busy are 0.
  - Age of voice i is i.
  - FSM goes to IDLE.
  - A message in flight is discarded with no output change.
- Classification of a message accepted in IDLE (status = s, data = note n, vel v; only bits [6:0] of n and v are used):
  - NOTE_ON: s[7:4]==4'h9 and v!=0.
  - NOTE_OFF: s[7:4]==4'h8, or s[7:4]==4'h9 with v==0.
  - Anything else, or a channel mismatch when the filter is on, is ignored: state stays IDLE and no busy is raised.
- FSM: IDLE -> SCAN (NUM_VOICES cycles, index 0..N-1, one voice examined per cycle) -> COMMIT (1 cycle) -> IDLE.
  - o_busy = (state != IDLE), registered.
  - A message strobed in cycle 0 gives busy in cycles 1..N+1.
  - Voice outputs, trig and steal update at the end of COMMIT and are visible in cycle N+2, the same cycle busy falls.
- Scan records:
  - match: lowest index with gate=1 and note==n.
  - free: lowest index with gate=0.
  - oldest: the index with age==N-1.
- NOTE_ON target, in priority order:
  - match (retrigger);
  - else free;
  - else oldest (steal, o_steal=1).
- NOTE_ON commit on target t:
  - gate[t]=1, note[t]=n, vel[t]=v, trig[t]=1 for one cycle.
  - Ages: every voice with age < old age[t] increments, and age[t]=0. Ages therefore always stay a permutation of 0..N-1.
- NOTE_OFF commit:
  - If match exists: gate[match]=0; note/vel retained; no trig; ages unchanged.
  - No match: no change.
- Busy collision: i_midi_valid while busy discards the message, o_drop=1 in the next cycle, and has no other effect.
- Strobe in the cycle busy falls is accepted normally.
- trig, steal and drop are all zero except in their single pulse cycle.
- All outputs are registered; there are no combinational paths from input to output.

Test Plan:
1. Reset, then strobe 0x90/60/100 -> busy high 5 cycles (N=4); in cycle 6 gate=0001, note0=60, vel0=100, trig=0001 for one cycle, steal=0.
2. Note-ons 60, 62, 64, 67 (each after busy falls), then 69 -> voices 0..3 hold 60/62/64/67; 69 steals voice 0 (steal=1, trig=0001, note0=69); next note-on 71 steals voice 1.
3. With 60/62 sounding: 0x80/62/0 -> voice1 gate 0, note1 still 62; 0x90/60/0 -> voice0 gate 0; 0x80/70 -> no output change.
4. With 60 sounding at vel 100: 0x90/60/20 -> same voice, vel=20, trig pulse on that voice only, no other gate changes, voice becomes youngest.
5. Strobe a second message 2 cycles after the first -> drop pulse one cycle later, only the first message takes effect; strobe exactly in the busy-fall cycle -> accepted.
6. CHANNEL_FILTER=1, MIDI_CHANNEL=0: 0x91/60/100 and 0xB0/07/64 -> no busy, no change; pull rst_n low during SCAN -> all outputs 0, FSM IDLE, message lost.

Source files
------------

// File: rtl/midi_voice_alloc.sv
// Polyphonic voice allocator: maps 3-byte MIDI note messages onto NUM_VOICES
// voices (retrigger, then free, then steal oldest) and drives registered
// per-voice note/velocity/gate/trigger lanes.
module midi_voice_alloc #(
  parameter int unsigned NUM_VOICES     = 4,
  parameter bit          CHANNEL_FILTER = 1'b0,
  parameter logic [3:0]  MIDI_CHANNEL   = 4'h0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [23:0]                 i_midi_bytes,
  input  logic                        i_midi_valid,
  output logic                        o_busy,
  output logic                        o_drop,
  output logic                        o_steal,
  output logic [NUM_VOICES-1:0]       o_voice_gate,
  output logic [NUM_VOICES-1:0]       o_voice_trig,
  output logic [7*NUM_VOICES-1:0]     o_voice_note,
  output logic [7*NUM_VOICES-1:0]     o_voice_vel
);

  localparam int unsigned IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int unsigned AW = IW;
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_VOICES - 1);
  localparam logic [AW-1:0] OLDEST_AGE = AW'(NUM_VOICES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   idx_q;
  logic            is_on_q;
  logic [6:0]      msg_note_q;
  logic [6:0]      msg_vel_q;
  logic            match_found_q;
  logic [IW-1:0]   match_idx_q;
  logic            free_found_q;
  logic [IW-1:0]   free_idx_q;
  logic [IW-1:0]   old_idx_q;

  logic            busy_q;
  logic            drop_q;
  logic            steal_q;
  logic [NUM_VOICES-1:0] gate_q;
  logic [NUM_VOICES-1:0] trig_q;
  logic [6:0]      vnote_q [NUM_VOICES];
  logic [6:0]      vvel_q  [NUM_VOICES];
  logic [AW-1:0]   age_q   [NUM_VOICES];

  logic [3:0]      status_hi_c;
  logic [3:0]      status_ch_c;
  logic [6:0]      in_note_c;
  logic [6:0]      in_vel_c;
  logic            msg_on_c;
  logic            msg_off_c;
  logic            chan_ok_c;
  logic            accept_c;
  logic            scan_hit_c;
  logic [IW-1:0]   tgt_c;
  logic            steal_c;
  logic            unused_bits_c;

  // Field extraction; only the low 7 bits of the data bytes are meaningful.
  assign status_hi_c   = i_midi_bytes[23:20];
  assign status_ch_c   = i_midi_bytes[19:16];
  assign in_note_c     = i_midi_bytes[14:8];
  assign in_vel_c      = i_midi_bytes[6:0];
  assign unused_bits_c = ^{i_midi_bytes[15], i_midi_bytes[7]};

  // Message classification: velocity-0 note-on is a note-off.
  always_comb begin
    msg_on_c  = 1'b0;
    msg_off_c = 1'b0;
    chan_ok_c = 1'b1;
    if (status_hi_c == 4'h9 && in_vel_c != 7'd0) begin
      msg_on_c = 1'b1;
    end
    if (status_hi_c == 4'h8 || (status_hi_c == 4'h9 && in_vel_c == 7'd0)) begin
      msg_off_c = 1'b1;
    end
    if (CHANNEL_FILTER && status_ch_c != MIDI_CHANNEL) begin
      chan_ok_c = 1'b0;
    end
    accept_c = chan_ok_c && (msg_on_c || msg_off_c);
  end

  // Voice under examination holds the message note and is sounding.
  assign scan_hit_c = gate_q[idx_q] && (vnote_q[idx_q] == msg_note_q);

  // Note-on target: retrigger beats free voice beats stealing the oldest.
  always_comb begin
    tgt_c   = old_idx_q;
    steal_c = 1'b0;
    if (match_found_q) begin
      tgt_c = match_idx_q;
    end else if (free_found_q) begin
      tgt_c = free_idx_q;
    end else begin
      steal_c = 1'b1;
    end
  end

  // Allocator FSM, scan bookkeeping and all registered voice state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      is_on_q       <= 1'b0;
      msg_note_q    <= '0;
      msg_vel_q     <= '0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      old_idx_q     <= '0;
      busy_q        <= 1'b0;
      drop_q        <= 1'b0;
      steal_q       <= 1'b0;
      gate_q        <= '0;
      trig_q        <= '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        vnote_q[i] <= '0;
        vvel_q[i]  <= '0;
        age_q[i]   <= AW'(i);
      end
    end else begin
      drop_q  <= 1'b0;
      steal_q <= 1'b0;
      trig_q  <= '0;
      case (state_q)
        IDLE: begin
          if (i_midi_valid && accept_c) begin
            is_on_q       <= msg_on_c;
            msg_note_q    <= in_note_c;
            msg_vel_q     <= in_vel_c;
            match_found_q <= 1'b0;
            free_found_q  <= 1'b0;
            idx_q         <= '0;
            busy_q        <= 1'b1;
            state_q       <= SCAN;
          end
        end
        SCAN: begin
          if (i_midi_valid) begin
            drop_q <= 1'b1;
          end
          if (scan_hit_c && !match_found_q) begin
            match_found_q <= 1'b1;
            match_idx_q   <= idx_q;
          end
          if (!gate_q[idx_q] && !free_found_q) begin
            free_found_q <= 1'b1;
            free_idx_q   <= idx_q;
          end
          if (age_q[idx_q] == OLDEST_AGE) begin
            old_idx_q <= idx_q;
          end
          if (idx_q == LAST_IDX) begin
            state_q <= COMMIT;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        COMMIT: begin
          if (i_midi_valid) begin
            drop_q <= 1'b1;
          end
          if (is_on_q) begin
            gate_q[tgt_c]  <= 1'b1;
            trig_q[tgt_c]  <= 1'b1;
            vnote_q[tgt_c] <= msg_note_q;
            vvel_q[tgt_c]  <= msg_vel_q;
            steal_q        <= steal_c;
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
              if (IW'(i) == tgt_c) begin
                age_q[i] <= '0;
              end else if (age_q[i] < age_q[tgt_c]) begin
                age_q[i] <= age_q[i] + AW'(1);
              end
            end
          end else if (match_found_q) begin
            gate_q[match_idx_q] <= 1'b0;
          end
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_busy       = busy_q;
  assign o_drop       = drop_q;
  assign o_steal      = steal_q;
  assign o_voice_gate = gate_q;
  assign o_voice_trig = trig_q;

  // Flatten per-voice registers onto the 7-bit lanes.
  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_lane
    assign o_voice_note[7*g +: 7] = vnote_q[g];
    assign o_voice_vel[7*g +: 7]  = vvel_q[g];
  end

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Scoreboard bench for midi_voice_alloc (4 voices, channel filter on channel 0).
module tb_midi_voice_alloc;

  localparam int NV = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [23:0]     i_midi_bytes;
  logic            i_midi_valid;
  logic            o_busy;
  logic            o_drop;
  logic            o_steal;
  logic [NV-1:0]   o_voice_gate;
  logic [NV-1:0]   o_voice_trig;
  logic [7*NV-1:0] o_voice_note;
  logic [7*NV-1:0] o_voice_vel;

  midi_voice_alloc #(
    .NUM_VOICES(NV),
    .CHANNEL_FILTER(1'b1),
    .MIDI_CHANNEL(4'h0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_midi_bytes(i_midi_bytes),
    .i_midi_valid(i_midi_valid),
    .o_busy(o_busy),
    .o_drop(o_drop),
    .o_steal(o_steal),
    .o_voice_gate(o_voice_gate),
    .o_voice_trig(o_voice_trig),
    .o_voice_note(o_voice_note),
    .o_voice_vel(o_voice_vel)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NV-1:0]   gate;
    logic [NV-1:0]   trig;
    logic            steal;
    logic [7*NV-1:0] note;
    logic [7*NV-1:0] vel;
  } exp_t;

  exp_t       sb_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  logic       m_gate [NV];
  logic [6:0] m_note [NV];
  logic [6:0] m_vel  [NV];
  int         m_age  [NV];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_gate[i] = 1'b0;
      m_note[i] = '0;
      m_vel[i]  = '0;
      m_age[i]  = i;
    end
  endtask

  task automatic snap(output exp_t e);
    e = '0;
    for (int i = 0; i < NV; i++) begin
      e.gate[i]        = m_gate[i];
      e.note[7*i +: 7] = m_note[i];
      e.vel[7*i +: 7]  = m_vel[i];
    end
  endtask

  // Reference behaviour of one message: classification, target choice, ages.
  task automatic model_msg(input logic [23:0] m, output bit acc, output exp_t e);
    logic [7:0] s;
    logic [6:0] n;
    logic [6:0] v;
    bit         on;
    bit         off;
    int         match;
    int         free;
    int         old;
    int         t;
    int         oa;
    bit         stl;
    logic [NV-1:0] trg;
    s   = m[23:16];
    n   = m[14:8];
    v   = m[6:0];
    on  = (s[7:4] == 4'h9) && (v != 0);
    off = (s[7:4] == 4'h8) || ((s[7:4] == 4'h9) && (v == 0));
    acc = (s[3:0] == 4'h0) && (on || off);
    stl = 1'b0;
    trg = '0;
    if (acc) begin
      match = -1;
      free  = -1;
      old   = -1;
      for (int i = 0; i < NV; i++) begin
        if (m_gate[i] && m_note[i] == n && match < 0) match = i;
        if (!m_gate[i] && free < 0) free = i;
        if (m_age[i] == NV - 1) old = i;
      end
      if (on) begin
        if (match >= 0) t = match;
        else if (free >= 0) t = free;
        else begin
          t   = old;
          stl = 1'b1;
        end
        oa = m_age[t];
        for (int i = 0; i < NV; i++) begin
          if (i == t) m_age[i] = 0;
          else if (m_age[i] < oa) m_age[i] = m_age[i] + 1;
        end
        m_gate[t] = 1'b1;
        m_note[t] = n;
        m_vel[t]  = v;
        trg[t]    = 1'b1;
      end else if (match >= 0) begin
        m_gate[match] = 1'b0;
      end
    end
    snap(e);
    e.trig  = trg;
    e.steal = stl;
  endtask

  task automatic cmp_out(input string tag, input exp_t e);
    chk({tag, ".gate"},  32'(o_voice_gate), 32'(e.gate));
    chk({tag, ".trig"},  32'(o_voice_trig), 32'(e.trig));
    chk({tag, ".steal"}, 32'(o_steal),      32'(e.steal));
    chk({tag, ".note"},  32'(o_voice_note), 32'(e.note));
    chk({tag, ".vel"},   32'(o_voice_vel),  32'(e.vel));
  endtask

  // Drive one strobe in the current cycle; push expectation if accepted.
  task automatic apply(input logic [23:0] m, output bit acc);
    exp_t e;
    model_msg(m, acc, e);
    if (acc) sb_q.push_back(e);
    i_midi_bytes = m;
    i_midi_valid = 1'b1;
    @(negedge clk);
    i_midi_valid = 1'b0;
  endtask

  // Follow busy down (bounded) and score the result on the busy-fall cycle.
  task automatic complete(input bit acc, input int exp_len);
    exp_t e;
    int   cnt;
    if (acc) begin
      chk("busy_rise", 32'(o_busy), 32'd1);
      cnt = 0;
      while (o_busy && cnt < 50) begin
        cnt++;
        @(negedge clk);
      end
      chk("busy_len", 32'(cnt), 32'(exp_len));
      chk("sb_depth", 32'(sb_q.size()), 32'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        cmp_out("commit", e);
      end
    end else begin
      chk("busy_ign", 32'(o_busy), 32'd0);
      snap(e);
      cmp_out("ignored", e);
    end
  endtask

  task automatic post();
    @(negedge clk);
    chk("trig_clr",  32'(o_voice_trig), 32'd0);
    chk("steal_clr", 32'(o_steal),      32'd0);
    chk("drop_clr",  32'(o_drop),       32'd0);
  endtask

  task automatic msg(input logic [23:0] m);
    bit acc;
    apply(m, acc);
    complete(acc, NV + 1);
    post();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".busy"},  32'(o_busy),       32'd0);
    chk({tag, ".drop"},  32'(o_drop),       32'd0);
    chk({tag, ".steal"}, 32'(o_steal),      32'd0);
    chk({tag, ".gate"},  32'(o_voice_gate), 32'd0);
    chk({tag, ".trig"},  32'(o_voice_trig), 32'd0);
    chk({tag, ".note"},  32'(o_voice_note), 32'd0);
    chk({tag, ".vel"},   32'(o_voice_vel),  32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete();
    model_reset();
    chk_zero("reset");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit acc;
    bit acc2;
    rst_n        = 1'b0;
    i_midi_bytes = '0;
    i_midi_valid = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_zero("por");

    // Basic note-on and latency
    msg(24'h903C64);

    // Fill all voices then steal the oldest twice
    msg(24'h903E64);
    msg(24'h904064);
    msg(24'h904364);
    msg(24'h904564);
    msg(24'h904764);

    // Note-off paths
    do_reset();
    msg(24'h903C64);
    msg(24'h903E64);
    msg(24'h803E00);
    msg(24'h903C00);
    msg(24'h804600);

    // Retrigger makes the voice youngest, so the next steal skips it
    do_reset();
    msg(24'h903C64);
    msg(24'h903E50);
    msg(24'h904050);
    msg(24'h904350);
    msg(24'h903C14);
    msg(24'h904564);

    // Collision: second strobe two cycles later is dropped
    apply(24'h904864, acc);
    @(negedge clk);
    i_midi_bytes = 24'h907F7F;
    i_midi_valid = 1'b1;
    @(negedge clk);
    i_midi_valid = 1'b0;
    chk("drop_pulse", 32'(o_drop), 32'd1);
    @(negedge clk);
    chk("drop_once", 32'(o_drop), 32'd0);
    complete(acc, NV - 2);
    post();

    // Strobe exactly in the busy-fall cycle is accepted
    apply(24'h904A64, acc);
    complete(acc, NV + 1);
    chk("fall_drop", 32'(o_drop), 32'd0);
    apply(24'h904C64, acc2);
    complete(acc2, NV + 1);
    post();

    // Channel filter and non-note messages are ignored
    msg(24'h913C64);
    msg(24'hB00740);
    msg(24'hA03C64);

    // Reset in the middle of a scan loses the message
    apply(24'h904E64, acc);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete();
    model_reset();
    chk_zero("scan_rst");
    @(negedge clk);
    chk_zero("scan_rst_idle");
    msg(24'h903C64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
